icache: RTL and testbench

Direct-mapped, read-only instruction cache between the PC/fetch stage and the memory arbiter. Takes the fetch address and read request from the datapath, returns the instruction word with `ihit` in the same cycle on a hit, and on a miss runs a blocking single-word fill from memory before hitting. It is the block that generates the `ihit` the PC stage uses to advance.

---
 rtl/icache_if.sv | 28 ++
 rtl/icache.sv | 126 ++++++++++++
 tb/tb_icache.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_if
// Purpose  : Fetch-side and memory-side signal bundle of the instruction cache
// Revision : 1.0
// ============================================================================
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  // master is the environment: datapath fetch request plus memory responses
  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );
endinterface
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module   : icache
// Purpose  : Direct-mapped read-only instruction cache, blocking single-word
//            fill. Define ICACHE_STATS_EN to build the hit/miss counters.
// Revision : 1.0
// ============================================================================
module icache #(
  parameter int NSETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  icache_if.slave     bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IDX = $clog2(NSETS);
  localparam int TAG = 30 - IDX;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  state_e           state_q;
  logic [31:2]      fill_addr_q;
  logic             iren_q;
  logic [31:0]      iaddr_q;
  logic [NSETS-1:0] valid_q;
  logic [TAG-1:0]   tag_q  [NSETS];
  logic [31:0]      data_q [NSETS];

  logic [IDX-1:0]   req_idx;
  logic [IDX-1:0]   fill_idx;
  logic [TAG-1:0]   req_tag;
  logic [TAG-1:0]   fill_tag;
  logic             hit;
  logic             miss_start;
  logic             fill_done;
  logic             unused_addr_lsb;

  assign req_idx  = bus.imemaddr[IDX+1:2];
  assign req_tag  = bus.imemaddr[31:IDX+2];
  assign fill_idx = fill_addr_q[IDX+1:2];
  assign fill_tag = fill_addr_q[31:IDX+2];

  assign unused_addr_lsb = ^bus.imemaddr[1:0];

  assign hit        = (state_q == IDLE) && bus.imemREN && valid_q[req_idx] &&
                      (tag_q[req_idx] == req_tag);
  assign miss_start = (state_q == IDLE) && bus.imemREN && !hit;
  assign fill_done  = (state_q == FETCH) && !bus.iwait;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      fill_addr_q <= '0;
      iren_q      <= 1'b0;
      iaddr_q     <= '0;
      valid_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_start) begin
            state_q     <= FETCH;
            fill_addr_q <= bus.imemaddr[31:2];
            iren_q      <= 1'b1;
            iaddr_q     <= {bus.imemaddr[31:2], 2'b00};
          end
        end
        FETCH: begin
          // the fill finishes regardless of what the fetch side does meanwhile
          if (!bus.iwait) begin
            state_q           <= IDLE;
            iren_q            <= 1'b0;
            iaddr_q           <= '0;
            valid_q[fill_idx] <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Frame payload needs no reset: valid_q gates every read of it.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      data_q[fill_idx] <= bus.iload;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

  assign bus.ihit     = hit;
  assign bus.imemload = hit ? data_q[req_idx] : 32'h0;
  assign bus.iREN     = iren_q;
  assign bus.iaddr    = iaddr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] hit_count_d;
  logic [31:0] miss_count_q;
  logic [31:0] miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q  + {31'd0, hit};
    miss_count_d = miss_count_q + {31'd0, miss_start};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache
// Purpose  : Scoreboard bench for icache against a behavioural cache model
// Revision : 1.0
// ============================================================================
module tb_icache;
  localparam int NSETS = 16;
  localparam int IDX   = $clog2(NSETS);

  logic        clk = 1'b0;
  logic        nRST;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache_if bus();

  icache #(.NSETS(NSETS)) dut (
    .CLK        (clk),
    .nRST       (nRST),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; int lat; int issue; } exp_t;
  typedef struct { logic [31:0] addr; int waits; } fill_t;

  exp_t        exp_q[$];
  fill_t       fill_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          m_valid [NSETS];
  logic [31:0] m_tag   [NSETS];
  int unsigned m_hits;
  int unsigned m_misses;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h40) return 32'h0050_0093;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % NSETS);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == (a >> (IDX + 2)));
  endfunction

  task automatic m_fill(input logic [31:0] a);
    m_valid[m_idx(a)] = 1'b1;
    m_tag[m_idx(a)]   = a >> (IDX + 2);
  endtask

  task automatic m_reset();
    for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic push_fill(input logic [31:0] a, input int w);
    fill_t f;
    f.addr  = {a[31:2], 2'b00};
    f.waits = w;
    fill_q.push_back(f);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: pops one queued fill per iREN burst, stalls for its wait count.
  bit          mem_active = 1'b0;
  int          mem_cnt    = 0;
  logic [31:0] mem_addr   = '0;
  fill_t       mem_f;
  initial begin
    bus.iwait = 1'b1;
    bus.iload = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.iREN) begin
        if (!mem_active) begin
          mem_active = 1'b1;
          chk("fill_expected", 32'(fill_q.size() != 0), 32'd1);
          if (fill_q.size() != 0) begin
            mem_f = fill_q.pop_front();
            chk("iaddr", bus.iaddr, mem_f.addr);
            mem_cnt = mem_f.waits;
          end else begin
            mem_cnt = 0;
          end
          mem_addr = bus.iaddr;
        end else begin
          chk("iaddr_stable", bus.iaddr, mem_addr);
        end
        if (mem_cnt > 0) begin
          bus.iwait = 1'b1;
          bus.iload = $urandom;
          mem_cnt--;
        end else begin
          bus.iwait = 1'b0;
          bus.iload = mem_word(mem_addr);
        end
      end else begin
        mem_active = 1'b0;
        bus.iwait  = 1'b1;
        bus.iload  = $urandom;
        chk("iaddr_idle", bus.iaddr, 32'h0);
      end
    end
  end

  exp_t mon_e;
  initial forever begin
    @(negedge clk);
    if (nRST) begin
      if (bus.ihit) begin
        if (exp_q.size() == 0) begin
          chk("spurious_ihit", 32'(bus.ihit), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("imemload", bus.imemload, mon_e.data);
          chk("latency", 32'(cyc - mon_e.issue), 32'(mon_e.lat));
        end
      end else begin
        chk("imemload_nohit", bus.imemload, 32'h0);
      end
    end
  end

  // One fetch; with chg set, the address moves to b one cycle into a's fill.
  task automatic fetch(input logic [31:0] a, input int w1, input bit chg,
                       input logic [31:0] b, input int w2);
    exp_t        e;
    logic [31:0] fin;
    int          lat;
    bit          got;
    @(posedge clk);
    #1;
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    e.issue      = cyc;
    lat          = 0;
    fin          = a;
    if (chg) begin
      push_fill(a, w1);
      m_fill(a);
      m_misses++;
      lat = w1 + 2;
      fin = b;
    end
    if (!m_hit(fin)) begin
      push_fill(fin, chg ? w2 : w1);
      m_fill(fin);
      m_misses++;
      lat += (chg ? w2 : w1) + 2;
    end
    m_hits++;
    e.data = mem_word(fin);
    e.lat  = lat;
    exp_q.push_back(e);
    if (chg) begin
      @(posedge clk);
      #1;
      bus.imemaddr = b;
    end
    got = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (bus.ihit) begin
        got = 1'b1;
        break;
      end
    end
    chk("fetch_done", 32'(got), 32'd1);
    if (!got) exp_q.delete();
  endtask

  task automatic idle(input logic [31:0] a);
    @(posedge clk);
    #1;
    bus.imemREN  = 1'b0;
    bus.imemaddr = a;
    @(negedge clk);
    chk("idle_ihit", 32'(bus.ihit), 32'd0);
    chk("idle_load", bus.imemload, 32'h0);
  endtask

  task automatic chk_counters();
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
`else
    chk("hit_count", hit_count, 32'h0);
    chk("miss_count", miss_count, 32'h0);
`endif
  endtask

  function automatic logic [31:0] rand_addr();
    return {22'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    logic [31:0] a;
    int          r;
    nRST         = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_ihit", 32'(bus.ihit), 32'd0);
    chk("rst_imemload", bus.imemload, 32'h0);
    chk("rst_iREN", 32'(bus.iREN), 32'd0);
    chk("rst_iaddr", bus.iaddr, 32'h0);
    chk("rst_hit_count", hit_count, 32'h0);
    chk("rst_miss_count", miss_count, 32'h0);
    nRST = 1'b1;

    fetch(32'h40, 3, 1'b0, 32'h0, 0);
    idle(32'h40);
    chk_counters();

    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 16; k++)
        fetch(32'(k * 4), 0, 1'b0, 32'h0, 0);
    idle(32'h3C);
    chk_counters();

    // Reset while a fill is outstanding; the frame must stay empty.
    @(posedge clk);
    #1;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h80;
    push_fill(32'h80, 6);
    @(posedge clk);
    @(negedge clk);
    chk("midfill_iREN", 32'(bus.iREN), 32'd1);
    nRST = 1'b0;
    #1;
    chk("async_rst_iREN", 32'(bus.iREN), 32'd0);
    chk("async_rst_iaddr", bus.iaddr, 32'h0);
    chk("async_rst_ihit", 32'(bus.ihit), 32'd0);
    m_reset();
    bus.imemREN = 1'b0;
    repeat (2) @(negedge clk);
    chk_counters();
    nRST = 1'b1;
    fetch(32'h80, 1, 1'b0, 32'h0, 0);

    fetch(32'h20, 2, 1'b1, 32'h24, 1);
    fetch(32'h20, 0, 1'b0, 32'h0, 0);
    fetch(32'h24, 0, 1'b0, 32'h0, 0);

    fetch(32'h10, 1, 1'b0, 32'h0, 0);
    fetch(32'h50, 2, 1'b0, 32'h0, 0);
    fetch(32'h10, 0, 1'b0, 32'h0, 0);
    idle(32'h10);
    idle(32'h10);
    chk_counters();

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      a = rand_addr();
      if (r == 0) idle(a);
      else if (r == 1 && !m_hit(a))
        fetch(a, $urandom_range(0, 3), 1'b1, rand_addr(), $urandom_range(0, 3));
      else
        fetch(a, $urandom_range(0, 3), 1'b0, 32'h0, 0);
    end
    idle(32'h0);
    chk_counters();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("fill_q_drained", 32'(fill_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
